// File: rtl/cpu_step_controller.sv
// Step/run/halt controller: issues one-cycle cpu_en strobes from buttons or slow_clk.
// Optional STEP_LIMIT_EN macro caps each free-run burst at MAX_STEPS strobes.
module cpu_step_controller #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int CNT_W           = 16,
   parameter int MAX_STEPS       = 1000
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic             btn_step,
   input  logic             btn_mode,
   input  logic             halt,
   output logic             cpu_en,
   output logic             run_mode,
   output logic             halted,
   output logic [CNT_W-1:0] step_count
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_STEP = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]      btn;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      db;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];
   logic            slow_q;
   logic            tick;
   logic            step_ev;
   logic            mode_ev;
   logic [1:0]      state;

`ifdef STEP_LIMIT_EN
   localparam int               RUN_W    = $clog2(MAX_STEPS + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STEPS - 1);
   logic [RUN_W-1:0] run_cnt;
`else
   // MAX_STEPS only matters when the step limit is built in
   logic unused_max_steps;
   assign unused_max_steps = (MAX_STEPS != 0);
`endif

   assign btn = {btn_mode, btn_step};

   // Two-flop synchronizer for the raw buttons
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Accept a new button level after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         db        <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press event on the cycle the debounced level is about to go 0->1
   always_comb begin
      press = '0;
      for (int i = 0; i < 2; i++) begin
         press[i] = sync2[i] & ~db[i] & (db_cnt[i] == DB_LAST);
      end
   end

   assign step_ev = press[0];
   assign mode_ev = press[1];

   // slow_clk rising-edge detector
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         slow_q <= 1'b0;
      end else begin
         slow_q <= slow_clk;
      end
   end

   assign tick = slow_clk & ~slow_q;

   // Mode FSM with registered strobe and strobe counter
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state      <= S_STEP;
         cpu_en     <= 1'b0;
         step_count <= '0;
`ifdef STEP_LIMIT_EN
         run_cnt    <= '0;
`endif
      end else begin
         cpu_en <= 1'b0;
         if (halt) begin
            state <= S_HALT;
         end else begin
            case (state)
               S_STEP: begin
                  if (mode_ev) begin
                     state <= S_RUN;
`ifdef STEP_LIMIT_EN
                     run_cnt <= '0;
`endif
                  end else if (step_ev) begin
                     cpu_en     <= 1'b1;
                     step_count <= step_count + 1'b1;
                  end
               end
               S_RUN: begin
                  if (mode_ev) begin
                     state <= S_STEP;
                  end else if (tick) begin
                     cpu_en     <= 1'b1;
                     step_count <= step_count + 1'b1;
`ifdef STEP_LIMIT_EN
                     run_cnt <= run_cnt + 1'b1;
                     if (run_cnt == RUN_LAST) begin
                        state <= S_STEP;
                     end
`endif
                  end
               end
               S_HALT: begin
                  if (mode_ev) begin
                     state <= S_STEP;
                  end
               end
               default: state <= S_STEP;
            endcase
         end
      end
   end

   assign run_mode = (state == S_RUN);
   assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed table, corner sequences, random run
// against a cycle-level behavioural model.
module tb_cpu_step_controller;

   localparam int DEB = 4;
   localparam int CW  = 4;
   localparam int MS  = 3;
`ifdef STEP_LIMIT_EN
   localparam int LIM = 1;
`else
   localparam int LIM = 0;
`endif

   logic          clk_in   = 1'b0;
   logic          reset    = 1'b1;
   logic          slow_clk = 1'b0;
   logic          btn_step = 1'b0;
   logic          btn_mode = 1'b0;
   logic          halt     = 1'b0;
   logic          cpu_en;
   logic          run_mode;
   logic          halted;
   logic [CW-1:0] step_count;

   cpu_step_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(CW),
      .MAX_STEPS(MS)
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .slow_clk(slow_clk),
      .btn_step(btn_step),
      .btn_mode(btn_mode),
      .halt(halt),
      .cpu_en(cpu_en),
      .run_mode(run_mode),
      .halted(halted),
      .step_count(step_count)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: modes 0=step, 1=run, 2=halt
   int m_mode, m_count, m_en, m_runn, m_slow;
   int m_s1 [2];
   int m_s2 [2];
   int m_db [2];
   int m_nh [2];
   int m_hist [2][DEB];

   function automatic void model_reset();
      m_mode  = 0;
      m_count = 0;
      m_en    = 0;
      m_runn  = 0;
      m_slow  = 0;
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 0;
         m_s2[i] = 0;
         m_db[i] = 0;
         m_nh[i] = 0;
      end
   endfunction

   function automatic void strobe();
      m_en    = 1;
      m_count = (m_count + 1) % (1 << CW);
   endfunction

   task automatic model_edge();
      int raw [2];
      int ev [2];
      int s2pre, tk, diff;
      if (reset) begin
         model_reset();
         return;
      end
      raw[0] = int'(btn_step);
      raw[1] = int'(btn_mode);
      for (int i = 0; i < 2; i++) begin
         s2pre   = m_s2[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
         for (int j = DEB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
         m_hist[i][0] = s2pre;
         if (m_nh[i] < DEB) m_nh[i]++;
         ev[i] = 0;
         diff  = 1;
         for (int j = 0; j < DEB; j++)
            if (m_hist[i][j] == m_db[i]) diff = 0;
         if (m_nh[i] == DEB && diff == 1) begin
            m_db[i] = s2pre;
            ev[i]   = m_db[i];
            m_nh[i] = 0;
         end
      end
      tk     = (slow_clk && m_slow == 0) ? 1 : 0;
      m_slow = int'(slow_clk);
      m_en   = 0;
      if (halt) begin
         m_mode = 2;
      end else if (m_mode == 0) begin
         if (ev[1] == 1) begin
            m_mode = 1;
            m_runn = 0;
         end else if (ev[0] == 1) begin
            strobe();
         end
      end else if (m_mode == 1) begin
         if (ev[1] == 1) begin
            m_mode = 0;
         end else if (tk == 1) begin
            strobe();
            m_runn++;
            if (LIM == 1 && m_runn == MS) m_mode = 0;
         end
      end else begin
         if (ev[1] == 1) m_mode = 0;
      end
   endtask

   task automatic tick_clk();
      @(posedge clk_in);
      model_edge();
      #1;
      chk("m_cpu_en", int'(cpu_en), m_en);
      chk("m_run_mode", int'(run_mode), (m_mode == 1) ? 1 : 0);
      chk("m_halted", int'(halted), (m_mode == 2) ? 1 : 0);
      chk("m_step_count", int'(step_count), m_count);
   endtask

   task automatic slow_edge(output int p);
      p = 0;
      slow_clk = 1'b1;
      tick_clk();
      p += int'(cpu_en);
      tick_clk();
      p += int'(cpu_en);
      slow_clk = 1'b0;
      tick_clk();
      p += int'(cpu_en);
   endtask

   task automatic mode_press();
      btn_mode = 1'b1;
      repeat (8) tick_clk();
      btn_mode = 1'b0;
      repeat (8) tick_clk();
   endtask

   typedef struct {
      logic bs;
      logic bm;
      logic sc;
      logic ht;
      int   n;
      int   ep;
      int   er;
      int   eh;
      int   ec;
   } vec_t;

   vec_t tbl [$];

   function automatic void add(logic bs, logic bm, logic sc, logic ht,
                               int n, int ep, int er, int eh, int ec);
      vec_t v;
      v.bs = bs; v.bm = bm; v.sc = sc; v.ht = ht;
      v.n = n; v.ep = ep; v.er = er; v.eh = eh; v.ec = ec;
      tbl.push_back(v);
   endfunction

   initial begin
      int pulses, p, tot;
      add(0,0,0,0,20,0,0,0,0);
      add(1,0,0,0,10,1,0,0,1);
      add(0,0,0,0,10,0,0,0,1);
      add(1,0,0,0, 2,0,0,0,1);
      add(0,0,0,0,10,0,0,0,1);
      add(0,1,0,0, 8,0,1,0,1);
      add(0,0,0,0, 8,0,1,0,1);
      for (int k = 0; k < 5; k++) begin
         add(0,0,1,0,3,1,1,0,2+k);
         add(0,0,0,0,3,0,1,0,2+k);
      end
      add(0,1,0,0, 8,0,0,0,6);
      add(0,0,0,0, 8,0,0,0,6);
      add(0,0,1,0, 3,0,0,0,6);
      add(0,0,0,0, 3,0,0,0,6);
      add(0,1,0,0, 8,0,1,0,6);
      add(0,0,0,0, 8,0,1,0,6);
      add(0,0,1,1, 3,0,0,1,6);
      add(0,0,0,1, 3,0,0,1,6);
      add(0,1,0,1, 8,0,0,1,6);
      add(0,0,0,1, 8,0,0,1,6);
      add(0,0,0,0, 4,0,0,1,6);
      add(0,1,0,0, 8,0,0,0,6);
      add(0,0,0,0, 8,0,0,0,6);

      model_reset();
      repeat (2) tick_clk();
      reset = 1'b0;

      foreach (tbl[r]) begin
         btn_step = tbl[r].bs;
         btn_mode = tbl[r].bm;
         slow_clk = tbl[r].sc;
         halt     = tbl[r].ht;
         pulses   = 0;
         repeat (tbl[r].n) begin
            tick_clk();
            pulses += int'(cpu_en);
         end
         chk($sformatf("row%0d_pulses", r), pulses, tbl[r].ep);
         chk($sformatf("row%0d_run_mode", r), int'(run_mode), tbl[r].er);
         chk($sformatf("row%0d_halted", r), int'(halted), tbl[r].eh);
         chk($sformatf("row%0d_count", r), int'(step_count), tbl[r].ec);
      end

      // Counter wrap 15 -> 0 -> 1, then reset during a strobe
      mode_press();
      chk("wrap_run_mode", int'(run_mode), 1);
      for (int e = 0; e < 9; e++) begin
         slow_edge(p);
         chk("wrap_pulse", p, 1);
      end
      chk("wrap_at15", int'(step_count), 15);
      slow_edge(p);
      chk("wrap_to0", int'(step_count), 0);
      slow_edge(p);
      chk("wrap_to1", int'(step_count), 1);
      slow_clk = 1'b1;
      tick_clk();
      chk("strobe_before_reset", int'(cpu_en), 1);
      reset = 1'b1;
      tick_clk();
      chk("rst_cpu_en", int'(cpu_en), 0);
      chk("rst_run_mode", int'(run_mode), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_count", int'(step_count), 0);
      reset    = 1'b0;
      slow_clk = 1'b0;
      repeat (3) tick_clk();

      // Run-mode burst with optional step limit
      mode_press();
      tot = 0;
      for (int e = 0; e < 5; e++) begin
         slow_edge(p);
         tot += p;
         if (e == 2) chk("limit_run_after3", int'(run_mode), LIM ? 0 : 1);
      end
      chk("limit_pulses", tot, LIM ? 3 : 5);
      chk("limit_count", int'(step_count), LIM ? 3 : 5);

      // Random stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) btn_step = ~btn_step;
         if ($urandom_range(9) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(2) == 0) slow_clk = ~slow_clk;
         if (halt) begin
            if ($urandom_range(5) == 0) halt = 1'b0;
         end else begin
            if ($urandom_range(59) == 0) halt = 1'b1;
         end
         tick_clk();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
